// File: rtl/alu_multicycle.sv
// alu_multicycle
// Registered ALU with a start/busy/done handshake. Logic, add, subtract and
// set-less-than complete one edge after start; the unsigned multiply is a
// shift-and-add loop that consumes one multiplier bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        operation request, ignored while busy
//   a, b         operands (WIDTH bits)
//   alu_control  opcode, sampled together with start
//   busy         high while a multiply is iterating
//   done         one-cycle pulse when result and flags have been updated
//   result       registered result, held until the next completion
//   zero         result == 0
//   carry        carry / no-borrow, or multiply upper-half nonzero
//   overflow     signed overflow for ADD/SUB
//   negative     result MSB
//
// WIDTH must be at least 4.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  state_t state;
  state_t next_state;

  // Multiplier working registers: the multiplicand is held double-width so it
  // can be shifted left into the upper half as the multiplier is consumed.
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      bit_cnt;

  // Single-cycle ALU outputs
  logic [WIDTH-1:0] b_mod;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;

  // Handshake decode
  logic accept_single;
  logic accept_mul;
  logic last_bit;
  logic mul_finish;

  // Completion load values
  logic             load;
  logic [WIDTH-1:0] new_result;
  logic             new_carry;
  logic             new_ovf;

  // State register: reset aborts any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: only a multiply leaves IDLE, and it returns once the
  // last multiplier bit has been folded into the accumulator.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start && (alu_control == OP_MUL)) begin
          next_state = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (last_bit) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs and handshake decode. start is only looked at in IDLE, which
  // is what makes a request during a multiply disappear without effect.
  always_comb begin
    busy          = (state == MUL_RUN);
    accept_single = (state == IDLE) && start && (alu_control != OP_MUL);
    accept_mul    = (state == IDLE) && start && (alu_control == OP_MUL);
    last_bit      = (bit_cnt == CW'(WIDTH - 1));
    mul_finish    = (state == MUL_RUN) && last_bit;
  end

  // Single-cycle ALU. SUB reuses the adder as a + ~b + 1 so the carry-out
  // directly means "no borrow"; overflow uses the inverted operand's sign.
  always_comb begin
    b_mod      = b;
    cin        = 1'b0;
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    if (alu_control == OP_SUB) begin
      b_mod = ~b;
      cin   = 1'b1;
    end
    sum = {1'b0, a} + {1'b0, b_mod} + {{WIDTH{1'b0}}, cin};
    case (alu_control)
      OP_AND: alu_result = a & b;
      OP_OR:  alu_result = a | b;
      OP_XOR: alu_result = a ^ b;
      OP_NOR: alu_result = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_result = sum[WIDTH-1:0];
        alu_carry  = sum[WIDTH];
        alu_ovf    = (a[WIDTH-1] == b_mod[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_result = '0;
    endcase
  end

  // One shift-and-add step, and selection of what gets written on completion.
  // The final multiply step's sum is loaded directly so no extra cycle is spent.
  always_comb begin
    acc_next   = mplier[0] ? (acc + mcand) : acc;
    load       = accept_single || mul_finish;
    new_result = mul_finish ? acc_next[WIDTH-1:0] : alu_result;
    new_carry  = mul_finish ? (|acc_next[2*WIDTH-1:WIDTH]) : alu_carry;
    new_ovf    = mul_finish ? 1'b0 : alu_ovf;
  end

  // Multiplier datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
    end else if (accept_mul) begin
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      acc     <= '0;
      bit_cnt <= '0;
    end else if (state == MUL_RUN) begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // Result/flag registers: written only at a completion edge, so they hold
  // steady through a multiply. done is a single-cycle pulse per completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      negative <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= load;
      if (load) begin
        result   <= new_result;
        zero     <= (new_result == '0);
        carry    <= new_carry;
        overflow <= new_ovf;
        negative <= new_result[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8. Single-cycle ops
// come from a vector table; multiply timing, ignored mid-run starts, reset
// abort and back-to-back completions are hand-written sequences.
module tb_alu_multicycle;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int NUM_VECS = 14;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        n;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  logic        start32;
  logic [31:0] a32;
  logic [31:0] b32;
  logic [2:0]  op32;
  logic        busy32;
  logic        done32;
  logic [31:0] result32;
  logic        zero32;
  logic        carry32;
  logic        ovf32;
  logic        neg32;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [2:0]  op8;
  logic        busy8;
  logic        done8;
  logic [7:0]  result8;
  logic        zero8;
  logic        carry8;
  logic        ovf8;
  logic        neg8;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[NUM_VECS];

  // Free-running clock shared by both instances
  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .start       (start32),
    .a           (a32),
    .b           (b32),
    .alu_control (op32),
    .busy        (busy32),
    .done        (done32),
    .result      (result32),
    .zero        (zero32),
    .carry       (carry32),
    .overflow    (ovf32),
    .negative    (neg32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .start       (start8),
    .a           (a8),
    .b           (b8),
    .alu_control (op8),
    .busy        (busy8),
    .done        (done8),
    .result      (result8),
    .zero        (zero8),
    .carry       (carry8),
    .overflow    (ovf8),
    .negative    (neg8)
  );

  // Compare one value and report a mismatch
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Compare result plus all four flags of one instance
  task automatic check_flags(input string tag, input bit narrow, input logic [31:0] res,
                             input logic z, input logic c, input logic v, input logic n);
    if (narrow) begin
      check_output({tag, " result"},   {24'h0, result8}, res);
      check_output({tag, " zero"},     {31'h0, zero8},   {31'h0, z});
      check_output({tag, " carry"},    {31'h0, carry8},  {31'h0, c});
      check_output({tag, " overflow"}, {31'h0, ovf8},    {31'h0, v});
      check_output({tag, " negative"}, {31'h0, neg8},    {31'h0, n});
    end else begin
      check_output({tag, " result"},   result32,         res);
      check_output({tag, " zero"},     {31'h0, zero32},  {31'h0, z});
      check_output({tag, " carry"},    {31'h0, carry32}, {31'h0, c});
      check_output({tag, " overflow"}, {31'h0, ovf32},   {31'h0, v});
      check_output({tag, " negative"}, {31'h0, neg32},   {31'h0, n});
    end
  endtask

  // Issue one op and count edges after the start edge until done (bounded)
  task automatic apply_stimulus(input bit narrow, input logic [2:0] op, input logic [31:0] opa,
                                input logic [31:0] opb, output int offset);
    @(negedge clk);
    if (narrow) begin
      start8 = 1'b1; op8 = op; a8 = opa[7:0]; b8 = opb[7:0];
    end else begin
      start32 = 1'b1; op32 = op; a32 = opa; b32 = opb;
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start32 = 1'b0;
    offset  = 0;
    while (!(narrow ? done8 : done32) && offset < 100) begin
      @(posedge clk);
      #1;
      offset++;
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic [2:0] op, input logic [31:0] opa,
                         input logic [31:0] opb, input logic [31:0] res,
                         input logic z, input logic c, input logic v, input logic n);
    vecs[i].name = name; vecs[i].op = op; vecs[i].a = opa; vecs[i].b = opb;
    vecs[i].res = res; vecs[i].z = z; vecs[i].c = c; vecs[i].v = v; vecs[i].n = n;
  endtask

  // Watchdog so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int offset;
    int done_count;

    //                name          op      a             b             result        z  c  v  n
    set_vec(0,  "add_1_2",      OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, 0);
    set_vec(1,  "sub_5_3",      OP_SUB, 32'h00000005, 32'h00000003, 32'h00000002, 0, 1, 0, 0);
    set_vec(2,  "add_0_0",      OP_ADD, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 0);
    set_vec(3,  "add_ovf",      OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 1);
    set_vec(4,  "add_carry",    OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0);
    set_vec(5,  "slt_neg_pos",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0);
    set_vec(6,  "slt_pos_neg",  OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 0);
    set_vec(7,  "and",          OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1);
    set_vec(8,  "or",           OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1);
    set_vec(9,  "xor",          OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0);
    set_vec(10, "nor",          OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0, 0);
    set_vec(11, "sub_borrow",   OP_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 1);
    set_vec(12, "sub_ovf",      OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 0);
    set_vec(13, "sub_equal",    OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0);

    reset   = 1'b1;
    start32 = 1'b0; a32 = '0; b32 = '0; op32 = OP_AND;
    start8  = 1'b0; a8  = '0; b8  = '0; op8  = OP_AND;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset busy32", {31'h0, busy32}, 32'h0);
    check_output("reset done32", {31'h0, done32}, 32'h0);
    check_flags("reset w32", 1'b0, 32'h0, 0, 0, 0, 0);
    check_output("reset busy8", {31'h0, busy8}, 32'h0);
    check_flags("reset w8", 1'b1, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle table
    for (int i = 0; i < NUM_VECS; i++) begin
      apply_stimulus(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, offset);
      check_output({vecs[i].name, " done_offset"}, 32'(offset), 32'd0);
      check_output({vecs[i].name, " busy"}, {31'h0, busy32}, 32'h0);
      check_flags(vecs[i].name, 1'b0, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].n);
    end
    @(posedge clk);
    #1;
    check_output("done_pulse_width", {31'h0, done32}, 32'h0);

    // Back-to-back: second start issued while done of the first is high
    @(negedge clk);
    start32 = 1'b1; op32 = OP_ADD; a32 = 32'h1; b32 = 32'h1;
    @(posedge clk);
    #1;
    check_output("b2b first done", {31'h0, done32}, 32'h1);
    check_output("b2b first result", result32, 32'h2);
    op32 = OP_OR; a32 = 32'h30; b32 = 32'h0C;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    check_output("b2b second done", {31'h0, done32}, 32'h1);
    check_output("b2b second result", result32, 32'h3C);
    @(posedge clk);
    #1;
    check_output("b2b done drops", {31'h0, done32}, 32'h0);

    // Multiply with a start pulse injected mid-run
    @(negedge clk);
    start32 = 1'b1; op32 = OP_MUL; a32 = 32'h0000FFFF; b32 = 32'h00010001;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    offset  = 0;
    check_output("mul busy after start", {31'h0, busy32}, 32'h1);
    check_output("mul no early done", {31'h0, done32}, 32'h0);
    while (!done32 && offset < 100) begin
      @(posedge clk);
      #1;
      offset++;
      if (offset == 5) begin
        start32 = 1'b1; op32 = OP_ADD; a32 = 32'h1; b32 = 32'h2;
      end
      if (offset == 6) start32 = 1'b0;
      if (offset == 10) begin
        check_output("mul result held", result32, 32'h3C);
        check_output("mul busy mid", {31'h0, busy32}, 32'h1);
      end
    end
    check_output("mul32 done_offset", 32'(offset), 32'd32);
    check_output("mul32 busy at done", {31'h0, busy32}, 32'h0);
    check_flags("mul32 ffff", 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check_output("mul ignored start no done", {31'h0, done32}, 32'h0);
    check_output("mul ignored start result", result32, 32'hFFFFFFFF);

    apply_stimulus(1'b0, OP_MUL, 32'h00010000, 32'h00010000, offset);
    check_output("mul32 ovf done_offset", 32'(offset), 32'd32);
    check_flags("mul32 ovf", 1'b0, 32'h0, 1, 1, 0, 0);

    // Restore a nonzero result so the reset clear is observable
    apply_stimulus(1'b0, OP_ADD, 32'h80000000, 32'h80000001, offset);
    check_flags("pre_reset add", 1'b0, 32'h00000001, 0, 1, 1, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    start32 = 1'b1; op32 = OP_MUL; a32 = 32'h0000FFFF; b32 = 32'h00010001;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_output("abort busy", {31'h0, busy32}, 32'h0);
    check_output("abort done", {31'h0, done32}, 32'h0);
    check_flags("abort", 1'b0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done32) done_count++;
    end
    check_output("abort no done", 32'(done_count), 32'd0);
    apply_stimulus(1'b0, OP_ADD, 32'h2, 32'h3, offset);
    check_output("post_abort add done_offset", 32'(offset), 32'd0);
    check_output("post_abort add result", result32, 32'h5);

    // Narrow instance
    apply_stimulus(1'b1, OP_MUL, 32'h0F, 32'h11, offset);
    check_output("mul8 done_offset", 32'(offset), 32'd8);
    check_flags("mul8 0f_11", 1'b1, 32'hFF, 0, 0, 0, 1);
    apply_stimulus(1'b1, OP_MUL, 32'h10, 32'h10, offset);
    check_output("mul8 ovf done_offset", 32'(offset), 32'd8);
    check_flags("mul8 ovf", 1'b1, 32'h00, 1, 1, 0, 0);
    apply_stimulus(1'b1, OP_ADD, 32'h7F, 32'h01, offset);
    check_output("add8 done_offset", 32'(offset), 32'd0);
    check_flags("add8 ovf", 1'b1, 32'h80, 0, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
